data_memory_responder: RTL and testbench



---
 rtl/data_memory_responder_pkg.sv | 13 +
 rtl/data_memory_responder_read_buffer.sv | 41 ++++
 rtl/data_memory_responder.sv | 88 ++++++++
 tb/tb_data_memory_responder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_responder_pkg.sv
// data_memory_responder_pkg: shared types and helpers for the data-memory responder.
package data_memory_responder_pkg;
  typedef logic [31:0] regval_t;
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BUS_READ  = 2'd1,
    BUS_WRITE = 2'd2
  } memory_state_t;
  localparam int unsigned TIMER_W = 16;
  function automatic regval_t word_address(input regval_t a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/data_memory_responder_read_buffer.sv
// data_memory_responder_read_buffer: single-word read buffer with hit compare and write coherence.
module data_memory_responder_read_buffer
  import data_memory_responder_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        fill_i,
  input  logic [29:0] fill_tag_i,
  input  regval_t     fill_data_i,
  input  logic        update_i,
  input  logic [29:0] update_tag_i,
  input  regval_t     update_data_i,
  input  logic        lookup_i,
  input  logic [29:0] lookup_tag_i,
  output logic        hit_o,
  output regval_t     data_o
);
  logic [29:0] tag_q, tag_d;
  regval_t     data_q, data_d;
  logic        valid_q, valid_d;
  logic        update_match;
  assign update_match = update_i && valid_q && update_tag_i == tag_q;
  always_comb begin
    valid_d = valid_q || fill_i;
    tag_d   = fill_i ? fill_tag_i : tag_q;
    data_d  = fill_i ? fill_data_i : update_match ? update_data_i : data_q;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end
  assign hit_o  = valid_q && lookup_i && lookup_tag_i == tag_q;
  assign data_o = data_q;
endmodule

// File: rtl/data_memory_responder.sv
// data_memory_responder: arbitrates stage reads and writes onto one word bus with wait states,
// serving held read requests from a coherent single-word buffer.
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter regval_t     ERROR_DATA     = 32'h0000_0000
) (
  input  logic    clock,
  input  logic    reset,
  input  logic    address_enable,
  input  regval_t address,
  output logic    data_valid,
  output regval_t data,
  input  logic    write_enable,
  input  regval_t write_address,
  input  regval_t write_data,
  output logic    write_done,
  output logic    bus_request,
  output logic    bus_write,
  output regval_t bus_address,
  output regval_t bus_write_data,
  input  logic    bus_ack,
  input  regval_t bus_read_data,
  output logic    bus_error
);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  memory_state_t      state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  regval_t            addr_q, addr_d, wdata_q, wdata_d;
  logic               write_done_q, write_done_d, bus_error_q, bus_error_d;
  logic               hit, in_bus, timed_out, finish, start_write, start_read, unused_ok;
  assign unused_ok   = ^{address[1:0], write_address[1:0]};
  assign in_bus      = state_q != IDLE;
  // An ack on the last allowed cycle still wins over the timeout.
  assign timed_out   = in_bus && !bus_ack && timer_q == TIMER_LAST;
  assign finish      = in_bus && (bus_ack || timed_out);
  // The cycle showing write_done still carries the old request, so it is not taken again.
  assign start_write = state_q == IDLE && write_enable && !write_done_q;
  assign start_read  = state_q == IDLE && !start_write && address_enable && !hit;
  always_comb begin
    state_d      = start_write ? BUS_WRITE : start_read ? BUS_READ : finish ? IDLE : state_q;
    timer_d      = (in_bus && !finish) ? timer_q + 1'b1 : '0;
    addr_d       = start_write ? word_address(write_address) :
                   start_read  ? word_address(address) : addr_q;
    wdata_d      = start_write ? write_data : wdata_q;
    write_done_d = state_q == BUS_WRITE && finish;
    bus_error_d  = timed_out;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      write_done_q <= 1'b0;
      bus_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      write_done_q <= write_done_d;
      bus_error_q  <= bus_error_d;
    end
  end
  data_memory_responder_read_buffer u_read_buffer (
    .clock         (clock),
    .reset         (reset),
    .fill_i        (state_q == BUS_READ && finish),
    .fill_tag_i    (addr_q[31:2]),
    .fill_data_i   (bus_ack ? bus_read_data : ERROR_DATA),
    .update_i      (state_q == BUS_WRITE && bus_ack),
    .update_tag_i  (addr_q[31:2]),
    .update_data_i (wdata_q),
    .lookup_i      (address_enable),
    .lookup_tag_i  (address[31:2]),
    .hit_o         (hit),
    .data_o        (data)
  );
  assign data_valid     = hit;
  assign write_done     = write_done_q;
  assign bus_request    = in_bus;
  assign bus_write      = state_q == BUS_WRITE;
  assign bus_address    = addr_q;
  assign bus_write_data = wdata_q;
  assign bus_error      = bus_error_q;
endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: directed scenarios followed by random reads/writes checked against
// a flat word-memory model behind a randomly delayed bus.
`timescale 1ns/1ps
module tb_data_memory_responder;
  import data_memory_responder_pkg::*;
  localparam regval_t ERR = 32'hE0E0_E0E0;
  logic    clock = 1'b0, reset = 1'b1;
  logic    address_enable = 1'b0, write_enable = 1'b0, bus_ack = 1'b0;
  regval_t address = '0, write_address = '0, write_data = '0, bus_read_data = '0;
  logic    data_valid, write_done, bus_request, bus_write, bus_error;
  regval_t data, bus_address, bus_write_data;
  int      vectors = 0, miscompares = 0;
  bit      auto_ack = 1'b0;
  logic    man_ack = 1'b0;
  regval_t man_data = '0;
  regval_t bus_mem [1024];
  regval_t ref_mem [1024];
  int      wait_left = 0;
  int      w;
  regval_t a;
  logic    got;

  data_memory_responder #(.TIMEOUT_CYCLES(4), .ERROR_DATA(ERR)) dut (
    .clock(clock), .reset(reset),
    .address_enable(address_enable), .address(address),
    .data_valid(data_valid), .data(data),
    .write_enable(write_enable), .write_address(write_address), .write_data(write_data),
    .write_done(write_done),
    .bus_request(bus_request), .bus_write(bus_write), .bus_address(bus_address),
    .bus_write_data(bus_write_data), .bus_ack(bus_ack), .bus_read_data(bus_read_data),
    .bus_error(bus_error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input regval_t obs, input regval_t exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ack_with(input regval_t d);
    man_ack  = 1'b1;
    man_data = d;
    tick();
    man_ack  = 1'b0;
  endtask

  // Bus slave: manual mode mirrors the main sequence, auto mode serves the memory model.
  initial forever begin
    @(negedge clock);
    if (!auto_ack) begin
      bus_ack       = man_ack;
      bus_read_data = man_data;
    end else begin
      bus_ack = 1'b0;
      if (bus_request) begin
        if (wait_left == 0) begin
          check("bus_align", bus_address[1:0], 0);
          if (bus_write) bus_mem[bus_address[11:2]] = bus_write_data;
          else bus_read_data = bus_mem[bus_address[11:2]];
          bus_ack   = 1'b1;
          wait_left = $urandom_range(0, 2);
        end else wait_left--;
      end
    end
  end

  initial begin
    #200000;
    $error("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      bus_mem[i] = $urandom;
      ref_mem[i] = bus_mem[i];
    end
    tick();
    check("rst_req", bus_request, 0);
    check("rst_wr", bus_write, 0);
    check("rst_addr", bus_address, 0);
    check("rst_wdata", bus_write_data, 0);
    check("rst_wdone", write_done, 0);
    check("rst_err", bus_error, 0);
    check("rst_dv", data_valid, 0);
    reset = 1'b0;
    tick();
    // Read miss
    address_enable = 1'b1; address = 32'h104; #1;
    check("miss_dv0", data_valid, 0);
    tick();
    check("miss_req", bus_request, 1);
    check("miss_addr", bus_address, 32'h104);
    check("miss_rd", bus_write, 0);
    tick(); tick();
    check("miss_wait_dv", data_valid, 0);
    ack_with(32'hDEADBEEF);
    check("miss_dv", data_valid, 1);
    check("miss_data", data, 32'hDEADBEEF);
    check("miss_idle", bus_request, 0);
    // Stall hold, then address change
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_dv", data_valid, 1);
      check("stall_data", data, 32'hDEADBEEF);
      check("stall_noreq", bus_request, 0);
    end
    address = 32'h108; #1;
    check("chg_dv", data_valid, 0);
    tick();
    check("chg_req", bus_request, 1);
    check("chg_addr", bus_address, 32'h108);
    ack_with(32'h1234_5678);
    check("chg_data", data, 32'h1234_5678);
    // Simultaneous write and read: write first
    write_enable = 1'b1; write_address = 32'h200; write_data = 32'h11; address = 32'h300; #1;
    tick();
    check("sim_bus_wr", bus_write, 1);
    check("sim_wr_addr", bus_address, 32'h200);
    check("sim_wr_data", bus_write_data, 32'h11);
    ack_with('0);
    check("sim_wdone", write_done, 1);
    check("sim_idle", bus_request, 0);
    tick();
    write_enable = 1'b0;
    check("sim_wdone_pulse", write_done, 0);
    check("sim_rd_req", bus_request, 1);
    check("sim_rd_wr", bus_write, 0);
    check("sim_rd_addr", bus_address, 32'h300);
    ack_with(32'h77);
    check("sim_rd_dv", data_valid, 1);
    check("sim_rd_data", data, 32'h77);
    // Coherence
    address = 32'h104; #1;
    tick();
    check("coh_rd_req", bus_request, 1);
    ack_with(32'hDEADBEEF);
    check("coh_fill", data, 32'hDEADBEEF);
    address_enable = 1'b0; write_enable = 1'b1; write_address = 32'h106; write_data = 32'h55;
    tick();
    check("coh_wr", bus_write, 1);
    check("coh_wr_addr", bus_address, 32'h104);
    ack_with('0);
    check("coh_wdone", write_done, 1);
    write_enable = 1'b0; address_enable = 1'b1; address = 32'h104; #1;
    check("coh_dv", data_valid, 1);
    check("coh_data", data, 32'h55);
    tick();
    check("coh_nobus", bus_request, 0);
    // Timeout
    address = 32'h40; #1;
    tick();
    check("to_req", bus_request, 1);
    check("to_addr", bus_address, 32'h40);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("to_wait_req", bus_request, 1);
      check("to_wait_err", bus_error, 0);
    end
    tick();
    check("to_err", bus_error, 1);
    check("to_idle", bus_request, 0);
    check("to_dv", data_valid, 1);
    check("to_data", data, ERR);
    tick();
    check("to_err_pulse", bus_error, 0);
    check("to_dv_hold", data_valid, 1);
    // Reset mid-read, late ack
    address = 32'h80; #1;
    tick();
    check("rr_req", bus_request, 1);
    reset = 1'b1; #1;
    check("rr_req0", bus_request, 0);
    check("rr_wr0", bus_write, 0);
    check("rr_addr0", bus_address, 0);
    check("rr_wdata0", bus_write_data, 0);
    check("rr_wdone0", write_done, 0);
    check("rr_err0", bus_error, 0);
    check("rr_dv0", data_valid, 0);
    address_enable = 1'b0;
    tick();
    reset = 1'b0;
    ack_with(32'hAA);
    check("rr_late_req", bus_request, 0);
    address_enable = 1'b1; address = 32'h40; #1;
    check("rr_buf_invalid", data_valid, 0);
    address_enable = 1'b0;
    tick();
    // Random traffic against the memory model
    auto_ack = 1'b1;
    tick();
    repeat (150) begin
      w = $urandom_range(0, 15);
      a = (regval_t'(w) << 2) | regval_t'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) begin
        write_address = a; write_data = $urandom; write_enable = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
          tick();
          got = write_done;
        end
        check("rnd_wdone", got, 1);
        if (got) ref_mem[w] = write_data;
        write_enable = 1'b0;
      end else begin
        address = a; address_enable = 1'b1; #1;
        got = data_valid;
        for (int k = 0; k < 20 && !got; k++) begin
          tick();
          got = data_valid;
        end
        check("rnd_dv", got, 1);
        check("rnd_data", data, ref_mem[w]);
        repeat ($urandom_range(0, 3)) begin
          tick();
          check("rnd_hold_dv", data_valid, 1);
          check("rnd_hold_data", data, ref_mem[w]);
        end
        if ($urandom_range(0, 1) == 1) address_enable = 1'b0;
      end
    end
    address_enable = 1'b0;
    tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
